countdown_ctrl: RTL and testbench
=================================

Name: countdown_ctrl

Overview:
- Sequencing controller for a 4-bit loadable down counter: active-low parallel load, CEP/CET count enables, Q, and TC.
- Drives the counter's load, enables and data, and watches Q.
- Provides a one-shot or auto-reload countdown timer with start/stop/pause control, a prescaled tick and an expiry pulse.
- Sits between software-style control strobes and the counter datapath.

Parameters:
- PRESCALE, 1, number of CP cycles per counter tick (1 = tick every cycle; legal 1..256).
- EXP_CNT_W, 8, width of the saturating expiry counter.

Ports:
- CP  input  1  clock, rising edge.
- CR  input  1  reset: synchronous, active-high.
- start  input  1  start or restart the countdown with `period`.
- stop  input  1  abort; return to IDLE.
- pause  input  1  level; freeze the count while high in RUN.
- reload  input  1  mode: 1 = auto-reload, 0 = one-shot; sampled on start.
- period  input  4  load value P; timer expires after P+1 ticks.
- cnt_q  input  4  counter Q.
- cnt_tc  input  1  counter TC.
- cnt_pe_n  output  1  counter parallel load, active-low.
- cnt_cep  output  1  counter CEP.
- cnt_cet  output  1  counter CET.
- cnt_d  output  4  counter load data.
- busy  output  1  high in LOAD, RUN and PAUSE.
- expire  output  1  one-cycle pulse per expiry.
- exp_count  output  EXP_CNT_W  number of expiries, saturating.
- err  output  1  sticky; see Optional Feature.

Behaviour:
- Reset (CR=1 at a CP edge):
  - state=IDLE, cnt_pe_n=1, cnt_cep=0, cnt_cet=0, cnt_d=0, busy=0, expire=0, exp_count=0, err=0.
  - Prescaler cleared; latched mode cleared.
  - Reset mid-run abandons the count; the counter Q is left as-is.
- Command priority: CR > stop > start > pause.
- States:
  - IDLE: counter enables low.
    - start → LOAD, latching period into cnt_d and reload into the mode register.
  - LOAD (exactly 1 cycle): cnt_pe_n=0, cnt_d=P.
    - Next state RUN; the prescaler is cleared on this edge.
  - RUN:
    - cnt_cet=1; cnt_cep=tick, where tick is the prescaler terminal (every cycle when PRESCALE=1).
    - Terminal tick = RUN & tick & cnt_q==0.
      - reload=1: cnt_pe_n=0 in that same cycle. Load overrides count, so Q goes to P with no wrap to 1111. Stay in RUN.
      - reload=0: cnt_cep=0 in that cycle. Q holds 0. Go to DONE.
    - pause=1 → PAUSE.
  - PAUSE: cnt_cep=0, cnt_cet=0; prescaler frozen.
    - pause=0 → RUN; the prescaler resumes from its frozen value.
  - DONE: enables low, busy=0.
    - Next start → LOAD. There is no automatic return to IDLE.
  - stop in any state → IDLE next edge; enables drop that cycle.
  - start in RUN, PAUSE or DONE → LOAD (restart with the new period and mode).
- Outputs:
  - cnt_pe_n, cnt_cep and cnt_cet are combinational decodes of state, tick and cnt_q.
  - All other outputs are registered.
- expire: high for one cycle, the cycle after the terminal-tick edge.
- exp_count: increments on that same edge and saturates at all-ones.
- Timing with PRESCALE=1:
  - start at cycle 0 → LOAD at cycle 1 → Q=P at cycle 2.
  - Terminal tick at cycle 2+P; expire at cycle 3+P.
  - In reload mode, expire repeats every P+1 cycles.
- Boundaries:
  - P=0: terminal tick on the first RUN tick.
  - start and pause together: start wins. A pause still held afterwards takes effect in the first RUN cycle.
  - stop on a terminal tick: no expire, exp_count unchanged.

Optional Feature:
- Macro: COUNTDOWN_TC_CHECK_EN.
- When defined:
  - err sets (sticky until CR) if cnt_tc=1 while state is RUN. This signals an unexpected wrap to 1111, i.e. a load/count conflict.
  - err also sets if cnt_q != cnt_d in the first RUN cycle after LOAD.
- When undefined: err tied to 0; no compare logic is instantiated.

Decomposition:
- Shared package (`include header):
  - State encodings: IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4; 3-bit state width.
  - Mode encodings.
- One sub-module: tick_prescaler, an up-counter mod PRESCALE with ports clr and hold, producing tick.

Test Plan:
- PRESCALE=1, P=3, reload=0, start pulse:
  - Q sequence 3,2,1,0 from cycle 2.
  - expire at cycle 6 only; DONE; exp_count=1; busy low from cycle 6.
- P=2, reload=1: expire every 3 cycles.
  - Q never reaches 1111.
  - exp_count=4 after four periods.
- PRESCALE=4, P=1, pause held for 5 cycles mid-run:
  - Q frozen while paused.
  - Expiry delayed by exactly 5 cycles versus the no-pause run.
- P=0: expire one cycle after the first RUN tick.
- stop on the terminal-tick cycle: no expire; state IDLE; exp_count unchanged.
- CR asserted in RUN:
  - All outputs at reset values next edge.
  - With COUNTDOWN_TC_CHECK_EN defined: forcing cnt_tc=1 in RUN sets err.

Source files
------------

// File: rtl/countdown_ctrl_pkg.sv
// Shared encodings for the countdown sequencing controller and its prescaler.
// Optional TC/load cross-check is enabled in the top with COUNTDOWN_TC_CHECK_EN.
package countdown_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic {
        MODE_ONESHOT = 1'b0,
        MODE_RELOAD  = 1'b1
    } mode_e;

    function automatic logic is_busy(input state_e s);
        return (s == ST_LOAD) || (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/countdown_ctrl_tick_prescaler.sv
// Modulo-PRESCALE up-counter; tick marks the last CP cycle of each counter tick.
// clr restarts the phase, hold freezes it (used while paused).
module countdown_ctrl_tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (hold_i) begin
            cnt_d = cnt_q;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown timer sequencer driving a 4-bit loadable down counter (load, CEP/CET, data).
// Define COUNTDOWN_TC_CHECK_EN to enable the sticky err cross-check of TC and loaded value.
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int PRESCALE  = 1,
    parameter int EXP_CNT_W = 8
) (
    input  logic                 CP,
    input  logic                 CR,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pause,
    input  logic                 reload,
    input  logic [3:0]           period,
    input  logic [3:0]           cnt_q,
    input  logic                 cnt_tc,
    output logic                 cnt_pe_n,
    output logic                 cnt_cep,
    output logic                 cnt_cet,
    output logic [3:0]           cnt_d,
    output logic                 busy,
    output logic                 expire,
    output logic [EXP_CNT_W-1:0] exp_count,
    output logic                 err
);

    state_e                 state_q, state_d;
    mode_e                  mode_q, mode_d;
    logic [3:0]             load_val_q, load_val_d;
    logic                   busy_q;
    logic                   expire_q;
    logic [EXP_CNT_W-1:0]   exp_count_q;
    logic                   tick_s;
    logic                   term_s;
    logic                   expiry_s;
    logic                   presc_clr_s;
    logic                   presc_hold_s;

    assign presc_clr_s  = (state_q == ST_LOAD);
    assign presc_hold_s = (state_q != ST_RUN);

    countdown_ctrl_tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk_i  (CP),
        .rst_i  (CR),
        .clr_i  (presc_clr_s),
        .hold_i (presc_hold_s),
        .tick_o (tick_s)
    );

    assign term_s   = (state_q == ST_RUN) && tick_s && (cnt_q == 4'd0);
    assign expiry_s = term_s && !stop;

    always_ff @(posedge CP) begin
        if (CR) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // stop beats start beats pause; a one-shot terminal tick ends in DONE
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        load_val_d = load_val_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d    = ST_LOAD;
            mode_d     = reload ? MODE_RELOAD : MODE_ONESHOT;
            load_val_d = period;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_LOAD:  state_d = ST_RUN;
                ST_RUN: begin
                    if (term_s && (mode_q == MODE_ONESHOT)) begin
                        state_d = ST_DONE;
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSE: state_d = pause ? ST_PAUSE : ST_RUN;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Counter strobes; a reload load overrides the count so Q never wraps through 1111
    always_comb begin
        cnt_pe_n = 1'b1;
        cnt_cep  = 1'b0;
        cnt_cet  = 1'b0;
        if (CR || stop) begin
            cnt_pe_n = 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: cnt_pe_n = 1'b0;
                ST_RUN: begin
                    cnt_cet = 1'b1;
                    cnt_cep = tick_s;
                    if (term_s && (mode_q == MODE_RELOAD)) begin
                        cnt_pe_n = 1'b0;
                    end else if (term_s) begin
                        cnt_cep = 1'b0;
                    end else begin
                        cnt_pe_n = 1'b1;
                    end
                end
                default: cnt_pe_n = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            mode_q      <= MODE_ONESHOT;
            load_val_q  <= 4'd0;
            busy_q      <= 1'b0;
            expire_q    <= 1'b0;
            exp_count_q <= '0;
        end else begin
            mode_q     <= mode_d;
            load_val_q <= load_val_d;
            busy_q     <= is_busy(state_d);
            expire_q   <= expiry_s;
            if (expiry_s && (exp_count_q != {EXP_CNT_W{1'b1}})) begin
                exp_count_q <= exp_count_q + EXP_CNT_W'(1);
            end
        end
    end

    assign cnt_d     = load_val_q;
    assign busy      = busy_q;
    assign expire    = expire_q;
    assign exp_count = exp_count_q;

`ifdef COUNTDOWN_TC_CHECK_EN
    logic err_q;
    logic first_run_q;

    // TC in RUN means the counter wrapped; first RUN cycle must show the loaded value
    always_ff @(posedge CP) begin
        if (CR) begin
            err_q       <= 1'b0;
            first_run_q <= 1'b0;
        end else begin
            first_run_q <= (state_q == ST_LOAD) && (state_d == ST_RUN);
            if ((state_q == ST_RUN) && (cnt_tc || (first_run_q && (cnt_q != load_val_q)))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_tc;
    assign unused_tc = cnt_tc;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl: two instances (PRESCALE=1 and 4) each closing the loop
// through a behavioural 4-bit down counter; table vectors plus hand-written corner sequences.
module tb_countdown_ctrl;

    logic CP = 1'b0;
    logic CR = 1'b1;
    logic start = 1'b0, stop = 1'b0, pause = 1'b0, reload = 1'b0;
    logic [3:0] period = 4'd0;
    logic tc_force = 1'b0;

    logic [3:0] q1 = 4'hA, q4 = 4'hA;
    logic tc1, pe1, cep1, cet1, busy1, exp1, err1;
    logic tc4, pe4, cep4, cet4, busy4, exp4, err4;
    logic [3:0] d1, d4;
    logic [7:0] ec1, ec4;

    int n_checks = 0;
    int n_errors = 0;

    initial forever #5 CP = ~CP;

    countdown_ctrl #(.PRESCALE(1), .EXP_CNT_W(8)) dut1 (
        .CP(CP), .CR(CR), .start(start), .stop(stop), .pause(pause), .reload(reload),
        .period(period), .cnt_q(q1), .cnt_tc(tc1), .cnt_pe_n(pe1), .cnt_cep(cep1),
        .cnt_cet(cet1), .cnt_d(d1), .busy(busy1), .expire(exp1), .exp_count(ec1), .err(err1));

    countdown_ctrl #(.PRESCALE(4), .EXP_CNT_W(8)) dut4 (
        .CP(CP), .CR(CR), .start(start), .stop(stop), .pause(pause), .reload(reload),
        .period(period), .cnt_q(q4), .cnt_tc(tc4), .cnt_pe_n(pe4), .cnt_cep(cep4),
        .cnt_cet(cet4), .cnt_d(d4), .busy(busy4), .expire(exp4), .exp_count(ec4), .err(err4));

    // Behavioural down counters: load has priority over count
    always @(posedge CP) begin
        if (!pe1) q1 <= d1; else if (cep1 && cet1) q1 <= q1 - 4'd1;
        if (!pe4) q4 <= d4; else if (cep4 && cet4) q4 <= q4 - 4'd1;
    end
    assign tc1 = tc_force | (cet1 & (q1 == 4'hF));
    assign tc4 = tc_force | (cet4 & (q4 == 4'hF));

    typedef struct {
        logic cr, st, sp, pa, rl;
        logic [3:0] per;
        logic chk;
        logic [3:0] q;
        logic pe, cep, cet;
        logic [3:0] d;
        logic bz, ex;
        logic [7:0] ec;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic cr, st, sp, pa, rl, input logic [3:0] per,
                                input logic chk, input logic [3:0] q, input logic pe, cep, cet,
                                input logic [3:0] d, input logic bz, ex, input logic [7:0] ec);
        vec_t v;
        v.cr = cr; v.st = st; v.sp = sp; v.pa = pa; v.rl = rl; v.per = per; v.chk = chk;
        v.q = q; v.pe = pe; v.cep = cep; v.cet = cet; v.d = d; v.bz = bz; v.ex = ex; v.ec = ec;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic do_reset();
        CR = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; tc_force = 1'b0;
        step();
        CR = 1'b0;
    endtask

    // PRESCALE=4, P=1 one-shot; optional pause held in cycles 3..7; returns expire cycle
    task automatic run_p4(input bit with_pause, output int t_exp);
        t_exp = -1;
        do_reset();
        start = 1'b1; period = 4'd1; reload = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            step();
            start = 1'b0;
            pause = with_pause && (c >= 3) && (c <= 7);
            #1;
            if (exp4 && (t_exp < 0)) t_exp = c;
            if (with_pause && (c >= 4) && (c <= 8))
                check($sformatf("pause_freeze_c%0d", c), {q4, cep4, cet4}, {4'd1, 1'b0, 1'b0});
        end
        pause = 1'b0;
    endtask

    initial begin
        int t_ref, t_pau;

        // T1: P=3 one-shot
        add(0,1,0,0,0,4'd3, 1, 4'hA,1,0,0,4'd0,0,0,8'd0);
        add(0,0,0,0,1,4'hF, 1, 4'hA,0,0,0,4'd3,1,0,8'd0);
        add(0,0,0,0,1,4'hF, 1, 4'd3,1,1,1,4'd3,1,0,8'd0);
        add(0,0,0,0,1,4'hF, 1, 4'd2,1,1,1,4'd3,1,0,8'd0);
        add(0,0,0,0,1,4'hF, 1, 4'd1,1,1,1,4'd3,1,0,8'd0);
        add(0,0,0,0,1,4'hF, 1, 4'd0,1,0,1,4'd3,1,0,8'd0);
        add(0,0,0,0,1,4'hF, 1, 4'd0,1,0,0,4'd3,0,1,8'd1);
        add(0,0,0,0,1,4'hF, 1, 4'd0,1,0,0,4'd3,0,0,8'd1);
        add(1,0,0,0,0,4'd0, 0, 4'd0,1,0,0,4'd0,0,0,8'd0);
        // T2: P=2 auto-reload, four periods then stop
        add(0,1,0,0,1,4'd2, 1, 4'd0,1,0,0,4'd0,0,0,8'd0);
        add(0,0,0,0,0,4'hF, 1, 4'd0,0,0,0,4'd2,1,0,8'd0);
        for (int k = 0; k < 4; k++) begin
            add(0,0,0,0,0,4'hF, 1, 4'd2,1,1,1,4'd2,1,(k > 0),8'(k));
            add(0,0,0,0,0,4'hF, 1, 4'd1,1,1,1,4'd2,1,0,8'(k));
            add(0,0,0,0,0,4'hF, 1, 4'd0,0,1,1,4'd2,1,0,8'(k));
        end
        add(0,0,0,0,0,4'hF, 1, 4'd2,1,1,1,4'd2,1,1,8'd4);
        add(0,0,1,0,0,4'hF, 1, 4'd1,1,0,0,4'd2,1,0,8'd4);
        add(0,0,0,0,0,4'hF, 1, 4'd1,1,0,0,4'd2,0,0,8'd4);
        add(1,0,0,0,0,4'd0, 0, 4'd0,1,0,0,4'd0,0,0,8'd0);
        // T3: P=0 one-shot
        add(0,1,0,0,0,4'd0, 1, 4'd1,1,0,0,4'd0,0,0,8'd0);
        add(0,0,0,0,1,4'hF, 1, 4'd1,0,0,0,4'd0,1,0,8'd0);
        add(0,0,0,0,1,4'hF, 1, 4'd0,1,0,1,4'd0,1,0,8'd0);
        add(0,0,0,0,1,4'hF, 1, 4'd0,1,0,0,4'd0,0,1,8'd1);
        // T4: restart from DONE, stop on the terminal tick
        add(0,1,0,0,0,4'd1, 1, 4'd0,1,0,0,4'd0,0,0,8'd1);
        add(0,0,0,0,0,4'hF, 1, 4'd0,0,0,0,4'd1,1,0,8'd1);
        add(0,0,0,0,0,4'hF, 1, 4'd1,1,1,1,4'd1,1,0,8'd1);
        add(0,0,1,0,0,4'hF, 1, 4'd0,1,0,0,4'd1,1,0,8'd1);
        add(0,0,0,0,0,4'hF, 1, 4'd0,1,0,0,4'd1,0,0,8'd1);
        // T5: CR in RUN, Q left as-is
        add(0,1,0,0,1,4'd5, 1, 4'd0,1,0,0,4'd1,0,0,8'd1);
        add(0,0,0,0,0,4'hF, 1, 4'd0,0,0,0,4'd5,1,0,8'd1);
        add(0,0,0,0,0,4'hF, 1, 4'd5,1,1,1,4'd5,1,0,8'd1);
        add(1,0,0,0,0,4'hF, 1, 4'd4,1,0,0,4'd5,1,0,8'd1);
        add(0,0,0,0,0,4'hF, 1, 4'd4,1,0,0,4'd0,0,0,8'd0);
        // T6: start with pause held, pause applies from the first RUN cycle
        add(0,1,0,1,0,4'd3, 1, 4'd4,1,0,0,4'd0,0,0,8'd0);
        add(0,0,0,1,0,4'hF, 1, 4'd4,0,0,0,4'd3,1,0,8'd0);
        add(0,0,0,1,0,4'hF, 1, 4'd3,1,1,1,4'd3,1,0,8'd0);
        add(0,0,0,1,0,4'hF, 1, 4'd2,1,0,0,4'd3,1,0,8'd0);
        add(0,0,0,0,0,4'hF, 1, 4'd2,1,0,0,4'd3,1,0,8'd0);
        add(0,0,0,0,0,4'hF, 1, 4'd2,1,1,1,4'd3,1,0,8'd0);
        add(0,0,0,0,0,4'hF, 1, 4'd1,1,1,1,4'd3,1,0,8'd0);
        add(0,0,0,0,0,4'hF, 1, 4'd0,1,0,1,4'd3,1,0,8'd0);
        add(0,0,0,0,0,4'hF, 1, 4'd0,1,0,0,4'd3,0,1,8'd1);

        // Reset state of both instances
        step();
        check("reset_dut1", {pe1, cep1, cet1, d1, busy1, exp1, ec1, err1}, {1'b1, 2'b00, 4'd0, 2'b00, 8'd0, 1'b0});
        check("reset_dut4", {pe4, cep4, cet4, d4, busy4, exp4, ec4, err4}, {1'b1, 2'b00, 4'd0, 2'b00, 8'd0, 1'b0});

        foreach (vq[i]) begin
            CR = vq[i].cr; start = vq[i].st; stop = vq[i].sp; pause = vq[i].pa;
            reload = vq[i].rl; period = vq[i].per;
            #1;
            if (vq[i].chk)
                check($sformatf("vec%0d", i),
                      {q1, pe1, cep1, cet1, d1, busy1, exp1, ec1},
                      {vq[i].q, vq[i].pe, vq[i].cep, vq[i].cet, vq[i].d, vq[i].bz, vq[i].ex, vq[i].ec});
            step();
        end

        // exp_count saturation: P=0 reload expires every cycle
        do_reset();
        start = 1'b1; period = 4'd0; reload = 1'b1;
        step();
        start = 1'b0;
        repeat (300) step();
        check("exp_count_sat", {ec1, exp1, busy1}, {8'hFF, 1'b1, 1'b1});

        // Pause on PRESCALE=4 delays expiry by exactly the paused cycles
        run_p4(1'b0, t_ref);
        run_p4(1'b1, t_pau);
        check("p4_expire_ref", 32'(t_ref), 32'd10);
        check("p4_expire_paused", 32'(t_pau), 32'd15);
        check("p4_pause_delay", 32'(t_pau - t_ref), 32'd5);

`ifdef COUNTDOWN_TC_CHECK_EN
        do_reset();
        start = 1'b1; period = 4'd5; reload = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        check("err_clear_in_run", {31'd0, err1}, 32'd0);
        tc_force = 1'b1;
        step();
        tc_force = 1'b0;
        #1;
        check("err_set_on_tc", {31'd0, err1}, 32'd1);
`else
        check("err_tied_low", {err1, err4}, 2'b00);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
